lsu_access_sequencer: RTL

//  Initiator-side front end of the load-store unit, placed in the MEM stage.

---
 rtl/lsu_access_sequencer_if.sv | 34 +++
 rtl/lsu_access_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/lsu_access_sequencer_if.sv
// Request/response, stall and LSU bus signals of the load-store access sequencer.
// The sequencer binds the slave modport; the pipeline/LSU side binds master.
interface lsu_access_sequencer_if;
  logic        i_req_valid;
  logic        i_req_ren;
  logic        i_req_wren;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_stall;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_misalign;
  logic [31:0] o_lsu_addr;
  logic        o_lsu_ren;
  logic        o_lsu_wren;
  logic [2:0]  o_lsu_funct3;
  logic [31:0] o_st_data;
  logic [31:0] i_ld_data;

  modport master (
    output i_req_valid, i_req_ren, i_req_wren, i_req_funct3, i_req_addr, i_req_wdata,
    output i_ld_data,
    input  o_stall, o_rsp_valid, o_rsp_rdata, o_misalign,
    input  o_lsu_addr, o_lsu_ren, o_lsu_wren, o_lsu_funct3, o_st_data
  );

  modport slave (
    input  i_req_valid, i_req_ren, i_req_wren, i_req_funct3, i_req_addr, i_req_wdata,
    input  i_ld_data,
    output o_stall, o_rsp_valid, o_rsp_rdata, o_misalign,
    output o_lsu_addr, o_lsu_ren, o_lsu_wren, o_lsu_funct3, o_st_data
  );
endinterface

// File: rtl/lsu_access_sequencer.sv
// MEM-stage load/store front end: turns one pipeline request into aligned LSU
// word reads (with extraction/extension here) or stores, splitting misaligned stores.
module lsu_access_sequencer #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  lsu_access_sequencer_if.slave bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {IDLE, RD0, RD1, RSP, WSPLIT} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q, wdata_q, w0_q, rdata_q, rdata_d;
  logic [2:0]        f3_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              cap_req, rdata_we;

  logic              req_st, req_ld, legal, misal;
  logic [2:0]        size_q, end_q;
  logic              cross_q;
  logic [XLEN-1:0]   word_q;
  logic [1:0]        last_q;

  // Sign/zero extension of the addressed bytes out of a two-word window.
  function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] dw,
                                              input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [XLEN-1:0] v;
    v = XLEN'(dw >> {off, 3'b000});
    case (f3)
      3'b000:  extract = {{24{v[7]}}, v[7:0]};
      3'b001:  extract = {{16{v[15]}}, v[15:0]};
      3'b010:  extract = v;
      3'b100:  extract = {24'b0, v[7:0]};
      3'b101:  extract = {16'b0, v[15:0]};
      default: extract = '0;
    endcase
  endfunction

  assign req_st = bus.i_req_valid & bus.i_req_wren;
  assign req_ld = bus.i_req_valid & ~bus.i_req_wren & bus.i_req_ren;
  assign legal  = bus.i_req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign misal  = legal &
                  (((bus.i_req_funct3[1:0] == 2'b01) & bus.i_req_addr[0]) |
                   ((bus.i_req_funct3[1:0] == 2'b10) & (bus.i_req_addr[1:0] != 2'b00)));

  assign size_q  = (f3_q[1:0] == 2'b00) ? 3'd1 : (f3_q[1:0] == 2'b01) ? 3'd2 : 3'd4;
  assign end_q   = {1'b0, addr_q[1:0]} + size_q;
  assign cross_q = end_q > 3'd4;
  assign word_q  = {addr_q[XLEN-1:2], 2'b00};
  assign last_q  = (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;

  // State and captured request
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      w0_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap_req) begin
        addr_q  <= bus.i_req_addr;
        wdata_q <= bus.i_req_wdata;
        f3_q    <= bus.i_req_funct3;
      end
      if (state_q == RD0) w0_q <= bus.i_ld_data;
      if (rdata_we) rdata_q <= rdata_d;
    end
  end

  // Next state and bus drive; everything held at zero while in reset
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    cap_req          = 1'b0;
    rdata_we         = 1'b0;
    rdata_d          = '0;
    bus.o_stall      = 1'b0;
    bus.o_misalign   = 1'b0;
    bus.o_lsu_addr   = '0;
    bus.o_lsu_ren    = 1'b0;
    bus.o_lsu_wren   = 1'b0;
    bus.o_lsu_funct3 = '0;
    bus.o_st_data    = '0;
    if (i_reset) begin
      case (state_q)
        IDLE: begin
          if (req_st || req_ld) begin
            cap_req        = 1'b1;
            bus.o_misalign = misal;
            if (!legal || (misal && !SPLIT_EN)) begin
              // Rejected: loads still owe the pipeline a zero response
              if (req_ld) begin
                rdata_we = 1'b1;
                state_d  = RSP;
              end
            end else if (req_ld) begin
              bus.o_stall      = 1'b1;
              bus.o_lsu_addr   = {bus.i_req_addr[XLEN-1:2], 2'b00};
              bus.o_lsu_ren    = 1'b1;
              bus.o_lsu_funct3 = 3'b010;
              state_d          = RD0;
            end else if (misal) begin
              bus.o_stall      = 1'b1;
              bus.o_lsu_addr   = bus.i_req_addr;
              bus.o_lsu_wren   = 1'b1;
              bus.o_lsu_funct3 = 3'b000;
              bus.o_st_data    = {24'b0, bus.i_req_wdata[7:0]};
              cnt_d            = 2'd1;
              state_d          = WSPLIT;
            end else begin
              bus.o_lsu_addr   = bus.i_req_addr;
              bus.o_lsu_wren   = 1'b1;
              bus.o_lsu_funct3 = {1'b0, bus.i_req_funct3[1:0]};
              bus.o_st_data    = bus.i_req_wdata;
            end
          end
        end
        RD0: begin
          bus.o_stall      = 1'b1;
          bus.o_lsu_addr   = word_q;
          bus.o_lsu_funct3 = 3'b010;
          if (cross_q) begin
            bus.o_lsu_addr = word_q + XLEN'(4);
            bus.o_lsu_ren  = 1'b1;
            state_d        = RD1;
          end else begin
            rdata_we = 1'b1;
            rdata_d  = extract({32'b0, bus.i_ld_data}, addr_q[1:0], f3_q);
            state_d  = RSP;
          end
        end
        RD1: begin
          bus.o_stall      = 1'b1;
          bus.o_lsu_addr   = word_q + XLEN'(4);
          bus.o_lsu_funct3 = 3'b010;
          rdata_we         = 1'b1;
          rdata_d          = extract({bus.i_ld_data, w0_q}, addr_q[1:0], f3_q);
          state_d          = RSP;
        end
        RSP: state_d = IDLE;
        WSPLIT: begin
          bus.o_lsu_addr   = addr_q + XLEN'(cnt_q);
          bus.o_lsu_wren   = 1'b1;
          bus.o_lsu_funct3 = 3'b000;
          bus.o_st_data    = {24'b0, wdata_q[{cnt_q, 3'b000} +: 8]};
          if (cnt_q == last_q) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            bus.o_stall = 1'b1;
            cnt_d       = cnt_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.o_rsp_valid = (state_q == RSP);
  assign bus.o_rsp_rdata = rdata_q;
endmodule
